// File: rtl/ahb_slave_interface.sv
// ahb_slave_interface
//
// Upstream stage of the AHB-to-APB bridge, between the AHB master and the
// APB FSM controller.
//  - Qualifies AHB transfers into a single-cycle `valid` (zero latency).
//  - Decodes the target APB peripheral into one-hot `tempselx`.
//  - Pipelines address, write data and direction two deep so the
//    controller can run back-to-back writes.
//  - Generates the two-cycle AHB ERROR response for unmapped addresses.
//  - Passes `Prdata` straight through as `Hrdata`.
//
// Parameters:
//   BASE_ADDR   start of the APB window
//   REGION_LOG2 log2 of the byte size of each of the 3 peripheral regions
//
// Ports:
//   Hclk, Hreset          clock, asynchronous active-high reset
//   Hwrite, Hreadyin      AHB direction, AHB bus ready
//   Htrans[1:0]           AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Haddr, Hwdata, Prdata AHB address, AHB write data, APB read data
//   valid                 qualified transfer to the mapped window
//   Haddr1/2, Hwdata1/2   address/data delayed 1/2 accepted cycles
//   Hwritereg             Hwrite delayed 1 accepted cycle
//   tempselx[2:0]         one-hot peripheral select
//   Hrdata                read data to AHB
//   Hresp[1:0]            AHB response (00 OKAY, 01 ERROR)
//   Hready_err            0 during the first ERROR cycle, else 1
//
// Optional feature, enabled by defining AHB_XFER_CNT_EN:
//   cnt_clr               synchronous clear of the transfer counter
//   xfer_count[15:0]      count of cycles with valid = 1 (wrapping)

module ahb_slave_interface #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          REGION_LOG2 = 26
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
`ifdef AHB_XFER_CNT_EN
    input  logic        cnt_clr,
    output logic [15:0] xfer_count,
`endif
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hready_err
);

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR1     = 2'b01,
        ERR2     = 2'b10
    } err_state_t;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Region bounds carried at 33 bits so a large REGION_LOG2 cannot overflow.
    localparam logic [32:0] REGION_END1 = 33'd1 << REGION_LOG2;
    localparam logic [32:0] REGION_END2 = REGION_END1 << 1;
    localparam logic [32:0] REGION_END3 = REGION_END2 + REGION_END1;

    err_state_t  state, state_nxt;
    logic [32:0] off;
    logic        mapped;
    logic        act;

    // ---------------- region decode ----------------
    // The offset is only trusted when Haddr >= BASE_ADDR; below the window
    // the subtraction wraps and must not be mistaken for a small offset.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        off      = {1'b0, Haddr - BASE_ADDR};
        mapped   = (Haddr >= BASE_ADDR) && (off < REGION_END3);
        tempselx = 3'b000;
        if (mapped) begin
            if (off < REGION_END1)      tempselx = 3'b001;
            else if (off < REGION_END2) tempselx = 3'b010;
            else                        tempselx = 3'b100;
        end
    end

    assign act    = Hreadyin && ((Htrans == TRANS_NONSEQ) || (Htrans == TRANS_SEQ));
    assign valid  = act && mapped;
    assign Hrdata = Prdata;

    // ---------------- address/data pipeline ----------------
    // Holds while Hreadyin is low so a wait-stated transfer stays stable.
    always_ff @(posedge Hclk or posedge Hreset) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge value of its source (Haddr2 takes
        // the old Haddr1, not the one written in the same edge).
        if (Hreset) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    // ---------------- error response FSM ----------------
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) state <= ERR_IDLE;
        else        state <= state_nxt;
    end

    // A bad address seen during ERR1 is not re-armed: the master cannot
    // issue a new address phase while Hready_err holds the bus low.
    always_comb begin
        state_nxt  = state;
        Hresp      = 2'b00;
        Hready_err = 1'b1;
        case (state)
            ERR_IDLE: begin
                if (act && !mapped) state_nxt = ERR1;
            end
            ERR1: begin
                Hresp      = 2'b01;
                Hready_err = 1'b0;
                state_nxt  = ERR2;
            end
            ERR2: begin
                Hresp     = 2'b01;
                state_nxt = (act && !mapped) ? ERR1 : ERR_IDLE;
            end
            default: state_nxt = ERR_IDLE;
        endcase
    end

`ifdef AHB_XFER_CNT_EN
    // ---------------- optional transfer counter ----------------
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset)       xfer_count <= '0;
        else if (cnt_clr) xfer_count <= '0;
        else if (valid)   xfer_count <= xfer_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
module tb_ahb_slave_interface;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam longint      RSZ  = 64'd1 << 26;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic        Hwrite = 1'b0;
    logic        Hreadyin = 1'b0;
    logic [1:0]  Htrans = 2'b00;
    logic [31:0] Haddr = '0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Prdata = '0;
    logic        valid;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hready_err;
`ifdef AHB_XFER_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] xfer_count;
`endif

    ahb_slave_interface dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
`ifdef AHB_XFER_CNT_EN
        .cnt_clr(cnt_clr), .xfer_count(xfer_count),
`endif
        .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
        .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .tempselx(tempselx),
        .Hrdata(Hrdata), .Hresp(Hresp), .Hready_err(Hready_err)
    );

    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_pass   = 0;
    bit quiet    = 1'b0;

    // Behavioural reference: accepted-transfer history plus the number of
    // cycles elapsed in the current error response (0 = none, 1 = first, 2 = second).
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w;
    int          m_err;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void model_map(input logic [31:0] a, output bit mapped, output logic [2:0] sel);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        mapped = (la >= lb) && (la < lb + 3 * RSZ);
        sel    = mapped ? 3'(1 << ((la - lb) / RSZ)) : 3'b000;
    endfunction

    task automatic model_reset();
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0;
        m_err = 0; m_cnt = '0;
    endtask

    // Applies one cycle of stimulus (called at posedge+1), checks every
    // output mid-cycle against the model, advances the model, returns at
    // the next posedge+1.
    task automatic cycle(input logic [1:0] tr, input logic rdy, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pr, input logic clr);
        bit         mp;
        logic [2:0] sel;
        bit         ex_valid;
        bit         bad;
        Htrans = tr; Hreadyin = rdy; Hwrite = wr; Haddr = a; Hwdata = d; Prdata = pr;
`ifdef AHB_XFER_CNT_EN
        cnt_clr = clr;
`endif
        @(negedge Hclk);
        model_map(a, mp, sel);
        ex_valid = rdy && tr[1] && mp;
        bad      = rdy && tr[1] && !mp;
        if (!quiet) begin
            check("valid", 32'(valid), 32'(ex_valid));
            check("tempselx", 32'(tempselx), 32'(sel));
            check("Hrdata", Hrdata, pr);
            check("Haddr1", Haddr1, m_a1);
            check("Haddr2", Haddr2, m_a2);
            check("Hwdata1", Hwdata1, m_d1);
            check("Hwdata2", Hwdata2, m_d2);
            check("Hwritereg", 32'(Hwritereg), 32'(m_w));
            check("Hresp", 32'(Hresp), (m_err != 0) ? 32'd1 : 32'd0);
            check("Hready_err", 32'(Hready_err), (m_err == 1) ? 32'd0 : 32'd1);
`ifdef AHB_XFER_CNT_EN
            check("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
        end
        if (rdy) begin
            m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = d; m_w = wr;
        end
        if (m_err == 1)  m_err = 2;
        else if (bad)    m_err = 1;
        else             m_err = 0;
        if (clr)           m_cnt = '0;
        else if (ex_valid) m_cnt = m_cnt + 16'd1;
        @(posedge Hclk); #1;
    endtask

    typedef struct {
        logic [1:0]  tr;
        logic        rdy;
        logic [31:0] a;
        logic        ex_valid;
        logic [2:0]  ex_sel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] A0, A1, A2, A3, D0, D1, D2, D3;

        vecs[0] = '{2'b10, 1'b1, 32'h8000_0010, 1'b1, 3'b001};
        vecs[1] = '{2'b11, 1'b1, 32'h8400_0000, 1'b1, 3'b010};
        vecs[2] = '{2'b10, 1'b1, 32'h8BFF_FFFF, 1'b1, 3'b100};
        vecs[3] = '{2'b10, 1'b1, 32'h8C00_0000, 1'b0, 3'b000};
        vecs[4] = '{2'b10, 1'b1, 32'h7FFF_FFFF, 1'b0, 3'b000};
        vecs[5] = '{2'b00, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
        vecs[6] = '{2'b01, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
        vecs[7] = '{2'b10, 1'b0, 32'h87FF_FFFC, 1'b0, 3'b010};
        vecs[8] = '{2'b10, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'b000};
        vecs[9] = '{2'b11, 1'b1, 32'h0000_0000, 1'b0, 3'b000};

        // ---- 1. reset with random inputs ----
        model_reset();
        for (int i = 0; i < 3; i++) begin
            Htrans = 2'($urandom); Hreadyin = 1'($urandom); Hwrite = 1'($urandom);
            Haddr = $urandom; Hwdata = $urandom; Prdata = $urandom;
            @(negedge Hclk);
            check("rst_Haddr1", Haddr1, 32'h0);
            check("rst_Haddr2", Haddr2, 32'h0);
            check("rst_Hwdata1", Hwdata1, 32'h0);
            check("rst_Hwdata2", Hwdata2, 32'h0);
            check("rst_Hwritereg", 32'(Hwritereg), 32'h0);
            check("rst_Hresp", 32'(Hresp), 32'h0);
            check("rst_Hready_err", 32'(Hready_err), 32'h1);
            @(posedge Hclk); #1;
        end
        Hreset = 1'b0;
        Htrans = 2'b10; Hreadyin = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0010;
        #1;
        check("first_valid", 32'(valid), 32'h1);
        check("first_sel", 32'(tempselx), 32'h1);
        cycle(2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'h1111_0000, 32'h0, 1'b0);

        // ---- 2. back-to-back writes ----
        A0 = 32'h8400_0000; A1 = 32'h8400_0004; A2 = 32'h8400_0008; A3 = 32'h8400_000C;
        D0 = 32'hD0D0_0000; D1 = 32'hD1D1_1111; D2 = 32'hD2D2_2222; D3 = 32'hD3D3_3333;
        cycle(2'b10, 1'b1, 1'b1, A0, D0, 32'h0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1, A1, D1, 32'h0, 1'b0);
        check("b2b_Haddr1", Haddr1, A1);
        check("b2b_Haddr2", Haddr2, A0);
        check("b2b_Hwdata2", Hwdata2, D0);
        check("b2b_Hwritereg", 32'(Hwritereg), 32'h1);
        cycle(2'b11, 1'b1, 1'b1, A2, D2, 32'h0, 1'b0);

        // ---- 3. wait states hold the pipeline ----
        cycle(2'b11, 1'b0, 1'b1, A3, D3, 32'h0, 1'b0);
        cycle(2'b11, 1'b0, 1'b1, A3, D3, 32'h0, 1'b0);
        check("ws_Haddr1", Haddr1, A2);
        check("ws_Haddr2", Haddr2, A1);
        check("ws_Hwdata1", Hwdata1, D2);
        check("ws_Hwdata2", Hwdata2, D1);
        cycle(2'b11, 1'b1, 1'b1, A3, D3, 32'h0, 1'b0);
        check("resume_Haddr1", Haddr1, A3);
        check("resume_Haddr2", Haddr2, A2);

        // ---- 4. unmapped: error sequence ----
        cycle(2'b10, 1'b1, 1'b0, 32'h8C00_0000, 32'h0, 32'h0, 1'b0);
        check("err1_Hresp", 32'(Hresp), 32'h1);
        check("err1_Hready_err", 32'(Hready_err), 32'h0);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("err2_Hresp", 32'(Hresp), 32'h1);
        check("err2_Hready_err", 32'(Hready_err), 32'h1);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("okay_Hresp", 32'(Hresp), 32'h0);
        // bad address issued during ERR2 re-enters ERR1 directly
        cycle(2'b10, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 32'h8C00_0000, 32'h0, 32'h0, 1'b0);
        check("b2b_err_Hresp", 32'(Hresp), 32'h1);
        check("b2b_err_Hready_err", 32'(Hready_err), 32'h0);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        // mapped transfer in ERR2 is valid
        Htrans = 2'b10; Hreadyin = 1'b1; Haddr = 32'h8000_0100;
        #1;
        check("err2_mapped_valid", 32'(valid), 32'h1);
        cycle(2'b10, 1'b1, 1'b1, 32'h8000_0100, 32'h5, 32'h0, 1'b0);
        check("after_err2_Hresp", 32'(Hresp), 32'h0);

        // reset asserted mid-ERR1 returns to OKAY immediately
        cycle(2'b10, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 1'b0);
        check("pre_rst_Hresp", 32'(Hresp), 32'h1);
        Hreset = 1'b1;
        #1;
        check("async_rst_Hresp", 32'(Hresp), 32'h0);
        check("async_rst_Hready_err", 32'(Hready_err), 32'h1);
        check("async_rst_Haddr1", Haddr1, 32'h0);
        model_reset();
        @(posedge Hclk); #1;
        Hreset = 1'b0;

        // ---- 5. table of decode edges and non-transfers ----
        foreach (vecs[i]) begin
            Htrans = vecs[i].tr; Hreadyin = vecs[i].rdy; Haddr = vecs[i].a;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(vecs[i].ex_valid));
            check($sformatf("tbl%0d_sel", i), 32'(tempselx), 32'(vecs[i].ex_sel));
            cycle(vecs[i].tr, vecs[i].rdy, 1'($urandom), vecs[i].a, $urandom, $urandom, 1'b0);
        end

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 4))
                0: a = $urandom;
                1: a = BASE + ($urandom % 32'h0C00_0000);
                2: a = BASE + 32'h0C00_0000 - 32'($urandom_range(0, 2));
                3: a = BASE - 32'($urandom_range(0, 2)) + 32'($urandom_range(0, 2));
                default: a = BASE + 32'h0400_0000 * 32'($urandom_range(0, 3)) - 32'($urandom_range(0, 1));
            endcase
            cycle(2'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), a,
                  $urandom, $urandom, ($urandom_range(0, 31) == 0));
        end

`ifdef AHB_XFER_CNT_EN
        // ---- 6. transfer counter ----
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(2'b10, 1'b1, 1'b1, BASE + 32'(4 * i), 32'h0, 32'h0, 1'b0);
        check("cnt_five", 32'(xfer_count), 32'd5);
        cycle(2'b10, 1'b1, 1'b1, BASE, 32'h0, 32'h0, 1'b1);
        check("cnt_clr_priority", 32'(xfer_count), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++)
            cycle(2'b10, 1'b1, 1'b1, BASE, 32'h0, 32'h0, 1'b0);
        quiet = 1'b0;
        check("cnt_full", 32'(xfer_count), 32'hFFFF);
        cycle(2'b10, 1'b1, 1'b1, BASE, 32'h0, 32'h0, 1'b0);
        check("cnt_wrap", 32'(xfer_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
Upstream stage of the AHB-to-APB bridge. It sits between the AHB master and the APB FSM controller.
- Qualifies AHB transfers into a single-cycle `valid`.
- Decodes the target APB peripheral into `tempselx`.
- Pipelines address, data and write direction two deep (`Haddr1/2`, `Hwdata1/2`, `Hwritereg`) so the controller can run back-to-back writes.
- Generates the AHB two-cycle ERROR response for unmapped addresses and returns `Prdata` as `Hrdata`.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of the APB window.
- REGION_LOG2, 26, log2 of the byte size of each of the 3 peripheral regions (64 MiB).

Ports:
- Hclk  in  1  bridge clock; all state updates on its rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Hwrite  in  1  AHB transfer direction (1 = write).
- Hreadyin  in  1  AHB bus ready; address phase accepted only when 1.
- Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data (data phase).
- Prdata  in  32  APB read data from the selected peripheral.
- valid  out  1  qualified transfer to the mapped window, this cycle.
- Haddr1  out  32  address, 1 accepted cycle delayed.
- Haddr2  out  32  address, 2 accepted cycles delayed.
- Hwdata1  out  32  write data, 1 accepted cycle delayed.
- Hwdata2  out  32  write data, 2 accepted cycles delayed.
- Hwritereg  out  1  `Hwrite`, 1 accepted cycle delayed.
- tempselx  out  3  one-hot peripheral select decoded from `Haddr`.
- Hrdata  out  32  read data to AHB.
- Hresp  out  2  AHB response (00 OKAY, 01 ERROR).
- Hready_err  out  1  0 during the first ERROR cycle, else 1. Bridge top ANDs it with the controller's `Hreadyout`.

Behaviour:
- Reset (`Hreset` = 1, asynchronous):
  - `Haddr1`, `Haddr2`, `Hwdata1`, `Hwdata2` = 0; `Hwritereg` = 0.
  - Error FSM in ERR_IDLE; `Hresp` = 00; `Hready_err` = 1.
  - Combinational outputs follow their equations.
- Region decode (combinational on `Haddr`), with `off = Haddr - BASE_ADDR`:
  - `mapped = (Haddr >= BASE_ADDR) && (off < 3<<REGION_LOG2)`.
  - `tempselx` = 001, 010 or 100 for `off>>REGION_LOG2` = 0, 1 or 2; 000 when unmapped.
- Active transfer: `act = Hreadyin && Htrans[1]` (NONSEQ or SEQ). IDLE and BUSY are never active.
- `valid = act && mapped`, combinational, zero latency; the controller consumes it the same cycle.
- Pipeline registers load only when `Hreadyin` = 1; otherwise they hold (wait-stated transfer keeps its address/data stable).
  - `Haddr1 <= Haddr`; `Haddr2 <= Haddr1`.
  - `Hwdata1 <= Hwdata`; `Hwdata2 <= Hwdata1`.
  - `Hwritereg <= Hwrite`.
- `Hrdata = Prdata`, combinational passthrough; the master samples it when the bridge `Hreadyout` = 1.
- Error FSM, states ERR_IDLE, ERR1, ERR2:
  - ERR_IDLE -> ERR1 when `act && !mapped`. `valid` stays 0, so the controller never sees the transfer.
  - ERR1: `Hresp` = 01, `Hready_err` = 0. Always -> ERR2.
  - ERR2: `Hresp` = 01, `Hready_err` = 1. -> ERR1 if `act && !mapped` (back-to-back bad address), else -> ERR_IDLE.
  - `Hresp` and `Hready_err` are decoded from state (registered timing).
  - ERR_IDLE: `Hresp` = 00, `Hready_err` = 1.
- Boundaries:
  - `Haddr` = BASE_ADDR + (3<<REGION_LOG2) - 1 is mapped (sel 100).
  - `Haddr` = BASE_ADDR + (3<<REGION_LOG2) is unmapped.
  - `Haddr` = BASE_ADDR - 1 is unmapped.
  - The subtraction must not wrap: compare before subtracting.
  - A mapped transfer in ERR2 asserts `valid` normally.
  - Reset mid-ERR1/ERR2 returns to ERR_IDLE immediately.

Optional Feature:
Macro `AHB_XFER_CNT_EN`.
- Defined:
  - Adds output `xfer_count` [15:0], reset 0.
  - Increments by 1 on every cycle with `valid` = 1, wrapping 16'hFFFF -> 0.
  - Adds input `cnt_clr` (1 bit), which synchronously zeroes the counter. `cnt_clr` has priority over an increment in the same cycle.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Reset: hold `Hreset` = 1 for 3 cycles with random inputs -> all pipeline regs 0, `Hresp` = 00, `Hready_err` = 1. Release, then NONSEQ write to 0x8000_0010 -> `valid` = 1, `tempselx` = 001 in the same cycle.
2. Back-to-back writes:
   - Stimulus: addresses A0 = 0x8400_0000, A1 = 0x8400_0004, A2 = 0x8400_0008 with data D0, D1, D2, `Hreadyin` = 1.
   - Cycle 3: `Haddr1` = A1, `Haddr2` = A0, `Hwdata2` = D0.
   - Throughout: `tempselx` = 010, `Hwritereg` = 1.
3. Wait state: drop `Hreadyin` for 2 cycles mid-burst -> `Haddr1`, `Haddr2`, `Hwdata1`, `Hwdata2` hold and `valid` = 0; values resume shifting when `Hreadyin` = 1.
4. Unmapped: NONSEQ read to 0x8C00_0000 -> `valid` = 0, then ERR1 (`Hresp` = 01, `Hready_err` = 0), then ERR2 (`Hresp` = 01, `Hready_err` = 1), then `Hresp` = 00. Repeat with a bad address issued in ERR2 -> ERR1 follows directly.
5. Edges and non-transfers:
   - 0x8BFF_FFFF -> `valid` = 1, `tempselx` = 100.
   - 0x7FFF_FFFF -> error sequence.
   - `Htrans` = IDLE or BUSY to a mapped address -> `valid` = 0, no error.
6. `AHB_XFER_CNT_EN`:
   - 5 valid transfers -> `xfer_count` = 5.
   - Preload 16'hFFFF + 1 valid -> 0.
   - `cnt_clr` coincident with `valid` -> 0.
